// File: rtl/conv2d_fwd_pkg.sv
// rtl/conv2d_fwd_pkg.sv - shared state encoding, Q-format constants and output-size helper for conv2d_fwd
package conv2d_fwd_pkg;

    typedef enum logic [1:0] {
        S_LOADW = 2'd0,
        S_LOADX = 2'd1,
        S_MAC   = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    localparam int FRAC_BITS = 16;
    localparam int ACC_W     = 72;
    localparam int DATA_W    = 32;
    localparam int PROD_W    = 64;

    // A negative numerator means no valid window; SV division would truncate it towards zero.
    function automatic int out_dim(input int in_sz, input int k, input int s, input int p, input int d);
        int num;
        num = in_sz + 2 * p - d * (k - 1) - 1;
        if (num < 0) return 0;
        return num / s + 1;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2d_fwd_mac.sv
// rtl/conv2d_fwd_mac.sv - single-tap multiply-accumulate with Q16.16 shift-and-saturate result register
module conv2d_fwd_mac
    import conv2d_fwd_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tap_en,
    input  logic                     first_tap,
    input  logic                     last_tap,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] pixel,
    input  logic signed [ACC_W-1:0]  acc_init,
    output logic signed [DATA_W-1:0] result
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum, acc_shr;
    logic signed [DATA_W-1:0] result_q, result_d, sat_val;

    // The first tap seeds from acc_init so no separate clear cycle is needed between outputs.
    always_comb begin
        prod    = PROD_W'(weight) * PROD_W'(pixel);
        acc_sum = (first_tap ? acc_init : acc_q) + ACC_W'(prod);
        acc_shr = acc_sum >>> FRAC_BITS;
        if ((acc_shr[ACC_W-1:DATA_W-1] == '0) || (acc_shr[ACC_W-1:DATA_W-1] == '1)) begin
            sat_val = acc_shr[DATA_W-1:0];
        end else if (acc_shr[ACC_W-1]) begin
            sat_val = 32'sh8000_0000;
        end else begin
            sat_val = 32'sh7FFF_FFFF;
        end
        acc_d    = tap_en ? acc_sum : acc_q;
        result_d = (tap_en && last_tap) ? sat_val : result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/conv2d_strided_padded_dilated_fwd.sv
// rtl/conv2d_strided_padded_dilated_fwd.sv - buffered strided/padded/dilated 2D convolution, one tap per cycle; CONV2D_FWD_BIAS_EN adds a bias word
module conv2d_strided_padded_dilated_fwd
    import conv2d_fwd_pkg::*;
#(
    parameter int IN_H     = 8,
    parameter int IN_W     = 12,
    parameter int K        = 3,
    parameter int STRIDE   = 2,
    parameter int PAD      = 1,
    parameter int DILATION = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        weight_valid,
    output logic        weight_ready,
    input  logic [31:0] weight_data,
    input  logic        valid_in,
    output logic        in_ready,
    input  logic [31:0] input_data,
    output logic        valid_out,
    input  logic        out_ready,
    output logic [31:0] output_data
);

    localparam int OUT_H = out_dim(IN_H, K, STRIDE, PAD, DILATION);
    localparam int OUT_W = out_dim(IN_W, K, STRIDE, PAD, DILATION);
    localparam int TAPS  = K * K;
    localparam int NPIX  = IN_H * IN_W;
`ifdef CONV2D_FWD_BIAS_EN
    localparam int NW    = TAPS + 1;
`else
    localparam int NW    = TAPS;
`endif
    localparam int TW    = clog2_min1(TAPS);
    localparam int AW    = clog2_min1(NPIX);

    localparam logic [15:0] NW_M1   = 16'(NW - 1);
    localparam logic [15:0] TAPS_16 = 16'(TAPS);
    localparam logic [15:0] TAPS_M1 = 16'(TAPS - 1);
    localparam logic [15:0] NPIX_M1 = 16'(NPIX - 1);
    localparam logic [15:0] K_M1    = 16'(K - 1);
    localparam logic [15:0] OH_M1   = 16'(OUT_H - 1);
    localparam logic [15:0] OW_M1   = 16'(OUT_W - 1);

    if (OUT_H < 1 || OUT_W < 1) begin : g_bad_dims
        $error("conv2d_strided_padded_dilated_fwd: output dimensions must be at least 1x1");
    end

    state_e      state_q, state_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] ky_q, ky_d, kx_q, kx_d;
    logic [15:0] oy_q, oy_d, ox_q, ox_d;
    logic        w_we, x_we;

    logic [DATA_W-1:0] weight_mem [TAPS];
    logic [DATA_W-1:0] frame_mem  [NPIX];

    int                       iy, ix;
    logic                     in_range;
    logic [AW-1:0]            pix_addr;
    logic signed [DATA_W-1:0] tap_weight, tap_pixel, mac_result;
    logic signed [ACC_W-1:0]  mac_init;
    logic                     mac_en, first_tap, last_tap;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        w_we    = 1'b0;
        x_we    = 1'b0;
        case (state_q)
            S_LOADW: begin
                if (weight_valid) begin
                    w_we = 1'b1;
                    if (wcnt_q == NW_M1) begin
                        wcnt_d  = '0;
                        state_d = S_LOADX;
                    end else begin
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end
            end
            S_LOADX: begin
                if (valid_in) begin
                    x_we = 1'b1;
                    if (pcnt_q == NPIX_M1) begin
                        pcnt_d  = '0;
                        state_d = S_MAC;
                    end else begin
                        pcnt_d = pcnt_q + 16'd1;
                    end
                end
            end
            S_MAC: begin
                if (kx_q == K_M1) begin
                    kx_d = '0;
                    ky_d = ky_q + 16'd1;
                end else begin
                    kx_d = kx_q + 16'd1;
                end
                if (tcnt_q == TAPS_M1) begin
                    tcnt_d  = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    state_d = S_OUT;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_MAC;
                    if (ox_q == OW_M1) begin
                        ox_d = '0;
                        if (oy_q == OH_M1) begin
                            oy_d    = '0;
                            state_d = S_LOADX;
                        end else begin
                            oy_d = oy_q + 16'd1;
                        end
                    end else begin
                        ox_d = ox_q + 16'd1;
                    end
                end
            end
            default: state_d = S_LOADW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOADW;
            wcnt_q  <= '0;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
        end
    end

    // Buffers are only ever read after being fully rewritten, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_we && (wcnt_q < TAPS_16)) begin
            weight_mem[wcnt_q[TW-1:0]] <= weight_data;
        end
        if (x_we) begin
            frame_mem[pcnt_q[AW-1:0]] <= input_data;
        end
    end

`ifdef CONV2D_FWD_BIAS_EN
    logic [DATA_W-1:0] bias_q, bias_d;

    always_comb begin
        bias_d = bias_q;
        if (w_we && (wcnt_q == TAPS_16)) begin
            bias_d = weight_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else begin
            bias_q <= bias_d;
        end
    end

    assign mac_init = {{(ACC_W - DATA_W - FRAC_BITS){bias_q[DATA_W-1]}}, bias_q, {FRAC_BITS{1'b0}}};
`else
    assign mac_init = '0;
`endif

    // Padding taps read an arbitrary address and are masked to zero.
    always_comb begin
        iy        = int'(oy_q) * STRIDE - PAD + int'(ky_q) * DILATION;
        ix        = int'(ox_q) * STRIDE - PAD + int'(kx_q) * DILATION;
        in_range  = (iy >= 0) && (iy < IN_H) && (ix >= 0) && (ix < IN_W);
        pix_addr  = AW'(iy * IN_W + ix);
        tap_pixel = in_range ? frame_mem[pix_addr] : '0;
        tap_weight = weight_mem[tcnt_q[TW-1:0]];
    end

    assign mac_en    = (state_q == S_MAC);
    assign first_tap = (tcnt_q == 16'd0);
    assign last_tap  = (tcnt_q == TAPS_M1);

    conv2d_fwd_mac u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .tap_en    (mac_en),
        .first_tap (first_tap),
        .last_tap  (last_tap),
        .weight    (tap_weight),
        .pixel     (tap_pixel),
        .acc_init  (mac_init),
        .result    (mac_result)
    );

    assign weight_ready = (state_q == S_LOADW);
    assign in_ready     = (state_q == S_LOADX);
    assign valid_out    = (state_q == S_OUT);
    assign output_data  = mac_result;

endmodule

// File: tb/tb_conv2d_strided_padded_dilated_fwd.sv
// tb/tb_conv2d_strided_padded_dilated_fwd.sv - randomized self-checking bench with a behavioural convolution model
module tb_conv2d_strided_padded_dilated_fwd;

    localparam int IN_H     = 8;
    localparam int IN_W     = 12;
    localparam int K        = 3;
    localparam int STRIDE   = 2;
    localparam int PAD      = 1;
    localparam int DILATION = 2;
    localparam int OH       = (IN_H + 2 * PAD - DILATION * (K - 1) - 1) / STRIDE + 1;
    localparam int OW       = (IN_W + 2 * PAD - DILATION * (K - 1) - 1) / STRIDE + 1;
    localparam int TAPS     = K * K;
    localparam int NPIX     = IN_H * IN_W;
    localparam int LAT      = K * K + 1;
`ifdef CONV2D_FWD_BIAS_EN
    localparam int NW       = TAPS + 1;
`else
    localparam int NW       = TAPS;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        weight_valid = 1'b0;
    logic        weight_ready;
    logic [31:0] weight_data = '0;
    logic        valid_in = 1'b0;
    logic        in_ready;
    logic [31:0] input_data = '0;
    logic        valid_out;
    logic        out_ready = 1'b0;
    logic [31:0] output_data;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          t_ref = 0;
    bit          t_ref_valid = 1'b0;
    bit          held = 1'b0;
    bit          hold_ready = 1'b0;
    bit          stall_en = 1'b0;
    int          stall_left = 0;
    int          out_idx = 0;

    logic [31:0] wl [TAPS+1];
    logic [31:0] x  [NPIX];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];

    conv2d_strided_padded_dilated_fwd #(
        .IN_H(IN_H), .IN_W(IN_W), .K(K), .STRIDE(STRIDE), .PAD(PAD), .DILATION(DILATION)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .weight_data  (weight_data),
        .valid_in     (valid_in),
        .in_ready     (in_ready),
        .input_data   (input_data),
        .valid_out    (valid_out),
        .out_ready    (out_ready),
        .output_data  (output_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Direct convolution from the definition: sum over in-range taps, floor-shift, clamp.
    function automatic void model_frame();
        logic signed [95:0] acc, a, b, r;
        logic [31:0] v;
        int iy, ix;
        for (int oy = 0; oy < OH; oy++) begin
            for (int ox = 0; ox < OW; ox++) begin
                acc = 0;
`ifdef CONV2D_FWD_BIAS_EN
                acc = $signed(wl[TAPS]);
                acc = acc * 65536;
`endif
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        iy = oy * STRIDE - PAD + ky * DILATION;
                        ix = ox * STRIDE - PAD + kx * DILATION;
                        if (iy >= 0 && iy < IN_H && ix >= 0 && ix < IN_W) begin
                            a = $signed(wl[ky * K + kx]);
                            b = $signed(x[iy * IN_W + ix]);
                            acc = acc + a * b;
                        end
                    end
                end
                r = acc >>> 16;
                if (r > 96'sd2147483647) v = 32'h7FFF_FFFF;
                else if (r < -96'sd2147483648) v = 32'h8000_0000;
                else v = r[31:0];
                exp_q.push_back(v);
            end
        end
    endfunction

    always @(negedge clk) begin
        #1;
        if (rst_n !== 1'b1) begin
            held = 1'b0;
        end else if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", output_data, 32'hxxxx_xxxx);
                out_ready = 1'b1;
            end else begin
                check("output_data", output_data, exp_q[0]);
                if (!held && t_ref_valid) check("output_latency", 32'(cyc - t_ref), 32'(LAT));
                if (hold_ready) out_ready = 1'b0;
                else if (stall_en && out_idx == 3 && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else out_ready = ($urandom_range(0, 3) != 0);
                if (out_ready) begin
                    got_q.push_back(output_data);
                    void'(exp_q.pop_front());
                    t_ref = cyc;
                    t_ref_valid = 1'b1;
                    held = 1'b0;
                    out_idx++;
                end else begin
                    held = 1'b1;
                end
            end
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        t_ref_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_weights(input int n);
        int i = 0;
        int g = 0;
        bit acc;
        while (i < n && g < 2000) begin
            @(negedge clk);
            weight_valid = ($urandom_range(0, 3) != 0);
            weight_data = wl[i];
            valid_in = 1'b1;
            input_data = $urandom;
            #1 acc = weight_valid && weight_ready;
            @(posedge clk);
            if (acc) i++;
            g++;
        end
        @(negedge clk);
        weight_valid = 1'b0;
        valid_in = 1'b0;
        check("weights_loaded", 32'(i), 32'(n));
    endtask

    task automatic send_frame();
        int i = 0;
        int g = 0;
        bit acc;
        while (i < NPIX && g < 5000) begin
            @(negedge clk);
            valid_in = ($urandom_range(0, 4) != 0);
            input_data = x[i];
            weight_valid = 1'($urandom_range(0, 1));
            weight_data = $urandom;
            #1 acc = valid_in && in_ready;
            if (acc && i == NPIX - 1) begin
                t_ref = cyc;
                t_ref_valid = 1'b1;
            end
            @(posedge clk);
            if (acc) i++;
            g++;
        end
        @(negedge clk);
        valid_in = 1'b0;
        weight_valid = 1'b0;
        check("frame_loaded", 32'(i), 32'(NPIX));
    endtask

    task automatic run_frame();
        int g = 0;
        got_q.delete();
        out_idx = 0;
        stall_left = 10;
        model_frame();
        send_frame();
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("outputs_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        check("next_frame_in_ready", 32'(in_ready), 32'd1);
        check("no_weight_reload", 32'(weight_ready), 32'd0);
    endtask

    task automatic rand_weights(input int shift);
        for (int i = 0; i <= TAPS; i++) wl[i] = $signed($urandom) >>> shift;
    endtask

    task automatic rand_frame(input int shift);
        for (int i = 0; i < NPIX; i++) x[i] = $signed($urandom) >>> shift;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_weight_ready", 32'(weight_ready), 32'd1);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_output_data", output_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // centre tap only: each output picks x[2oy+1][2ox+1]
        for (int i = 0; i <= TAPS; i++) wl[i] = '0;
        wl[4] = 32'h0001_0000;
        for (int i = 0; i < NPIX; i++) x[i] = 32'(i) << 16;
        send_weights(NW);
        @(negedge clk);
        weight_valid = 1'b1;
        weight_data = 32'hDEAD_BEEF;
        #1 check("extra_weight_refused", 32'(weight_ready), 32'd0);
        run_frame();
        check("centre_out00", got_q[0], 32'h000D_0000);
        check("centre_out24", got_q[14], 32'h0045_0000);
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++)
                check("centre_pick", got_q[oy * OW + ox], 32'(((2 * oy + 1) * IN_W + 2 * ox + 1) << 16));

        // corner tap only: out(0,0) lands fully in padding
        do_reset();
        for (int i = 0; i <= TAPS; i++) wl[i] = '0;
        wl[0] = 32'h0001_0000;
        send_weights(NW);
        run_frame();
        check("tap00_out00_padded", got_q[0], 32'h0000_0000);
        check("tap00_out11", got_q[6], 32'h000D_0000);

        // saturation in both directions
        do_reset();
        for (int i = 0; i < TAPS; i++) wl[i] = 32'h7FFF_0000;
        wl[TAPS] = '0;
        for (int i = 0; i < NPIX; i++) x[i] = 32'h7FFF_0000;
        send_weights(NW);
        run_frame();
        for (int i = 0; i < OH * OW; i++) check("sat_pos", got_q[i], 32'h7FFF_FFFF);
        do_reset();
        for (int i = 0; i < TAPS; i++) wl[i] = 32'h8001_0000;
        send_weights(NW);
        run_frame();
        for (int i = 0; i < OH * OW; i++) check("sat_neg", got_q[i], 32'h8000_0000);

        // backpressure stall on output 3, then a second frame on the same weights
        do_reset();
        rand_weights(12);
        rand_frame(8);
        send_weights(NW);
        stall_en = 1'b1;
        run_frame();
        stall_en = 1'b0;
        check("stall_output_count", 32'(got_q.size()), 32'(OH * OW));
        rand_frame(8);
        run_frame();

        // reset while accumulating
        do_reset();
        rand_weights(12);
        rand_frame(8);
        send_weights(NW);
        send_frame();
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        t_ref_valid = 1'b0;
        #1;
        check("mac_reset_valid_out", 32'(valid_out), 32'd0);
        check("mac_reset_weight_ready", 32'(weight_ready), 32'd1);
        check("mac_reset_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("frame_needs_weights", 32'(in_ready), 32'd0);
        rand_weights(12);
        send_weights(NW);
        rand_frame(8);
        run_frame();

        // reset while an output is pending
        do_reset();
        rand_weights(10);
        rand_frame(6);
        send_weights(NW);
        hold_ready = 1'b1;
        got_q.delete();
        model_frame();
        send_frame();
        begin
            int g = 0;
            while (!valid_out && g < 100) begin
                @(negedge clk);
                #2;
                g++;
            end
        end
        check("reached_output", 32'(valid_out), 32'd1);
        #1 rst_n = 1'b0;
        t_ref_valid = 1'b0;
        #1;
        check("out_reset_valid_out", 32'(valid_out), 32'd0);
        check("out_reset_output_data", output_data, 32'd0);
        exp_q.delete();
        hold_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // wide-range random weights and pixels, some outputs saturate
        rand_weights(0);
        send_weights(NW);
        rand_frame(4);
        run_frame();
        rand_frame(0);
        run_frame();

`ifdef CONV2D_FWD_BIAS_EN
        do_reset();
        for (int i = 0; i < TAPS; i++) wl[i] = '0;
        wl[TAPS] = 32'h0000_8000;
        send_weights(NW);
        rand_frame(0);
        run_frame();
        for (int i = 0; i < OH * OW; i++) check("bias_only", got_q[i], 32'h0000_8000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual cycle %0d required finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
